// File: rtl/fram_arb_pkg.sv
// fram_arb_pkg: shared types and bank-mapping helpers
// for the feature-SRAM port-B arbiter.
package fram_arb_pkg;

  // Entries are stored at a fixed maximum width; the arbiter
  // uses the low ADDR_WIDTH / DATA_WIDTH bits.
  localparam int unsigned ARB_AW_MAX = 32;
  localparam int unsigned ARB_DW_MAX = 64;

  typedef struct packed {
    logic [ARB_AW_MAX-1:0] addr;
    logic [ARB_DW_MAX-1:0] data;
  } wq_entry_t;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    DONE
  } arb_state_e;

  function automatic logic [ARB_AW_MAX-1:0] bank_of(
    input logic [ARB_AW_MAX-1:0] a,
    input int unsigned           bits
  );
    return a & ((ARB_AW_MAX'(1) << bits) - ARB_AW_MAX'(1));
  endfunction

  function automatic logic [ARB_AW_MAX-1:0] bankaddr_of(
    input logic [ARB_AW_MAX-1:0] a,
    input int unsigned           bits
  );
    return a >> bits;
  endfunction

endpackage

// File: rtl/fram_wq_fifo.sv
// fram_wq_fifo: circular write-back queue with head view
// and youngest-match address lookup.
module fram_wq_fifo
  import fram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wq_entry_t               push_entry,
  input  logic                    pop,
  input  logic [ARB_AW_MAX-1:0]   look_addr,
  output wq_entry_t               head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    hit,
  output logic [ARB_DW_MAX-1:0]   hit_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  wq_entry_t     mem [DEPTH];
  logic [PW-1:0] hd_q;
  logic [PW-1:0] tl_q;
  logic [PW:0]   cnt_q;
  logic [PW-1:0] idx;

  // pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) tl_q <= tl_q + 1'b1;
      if (pop)  hd_q <= hd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[tl_q] <= push_entry;
  end

  assign head  = mem[hd_q];
  assign count = cnt_q;

  // scan oldest to youngest so the youngest match wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = hd_q + PW'(i);
      if (((PW+1)'(i) < cnt_q) &&
          (mem[idx].addr == look_addr)) begin
        hit      = 1'b1;
        hit_data = mem[idx].data;
      end
    end
  end

endmodule

// File: rtl/fram_bank_arbiter.sv
// fram_bank_arbiter: feature-SRAM port-B arbiter; reads own
// the bank, write-backs queue. Option macro: FRAM_ARB_FWD_EN.
module fram_bank_arbiter
  import fram_arb_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 14,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned BANK_NUM   = 4,
  parameter  int unsigned WQ_DEPTH   = 4,
  parameter  int unsigned RD_LATENCY = 1,
  localparam int unsigned BW  = $clog2(BANK_NUM),
  localparam int unsigned BAW = ADDR_WIDTH - BW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rp_en,
  input  logic [ADDR_WIDTH-1:0] rp_addr,
  output logic [DATA_WIDTH-1:0] rp_rdata,
  output logic                  rp_rvalid,
  input  logic                  wp_valid,
  input  logic [ADDR_WIDTH-1:0] wp_addr,
  input  logic [DATA_WIDTH-1:0] wp_wdata,
  output logic                  wp_ready,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  wq_empty,
  output logic                  proto_err,
`ifndef FRAM_ARB_FWD_EN
  output logic                  raw_hazard,
`endif
  output logic [BAW-1:0]        bram_addr  [BANK_NUM],
  output logic [DATA_WIDTH-1:0] bram_wdata [BANK_NUM],
  output logic [BANK_NUM-1:0]   bram_we,
  output logic [BANK_NUM-1:0]   bram_en,
  input  logic [DATA_WIDTH-1:0] bram_rdata [BANK_NUM]
);

  localparam int unsigned CW = $clog2(WQ_DEPTH) + 1;
  localparam int unsigned RL = RD_LATENCY;
  localparam logic [CW-1:0] QFULL = CW'(WQ_DEPTH);

  logic [ARB_AW_MAX-1:0] rd_ax;
  wq_entry_t             push_e;
  wq_entry_t             head;
  logic [CW-1:0]         count;
  logic                  wq_hit;
  logic [ARB_DW_MAX-1:0] wq_hit_data;
  logic [BW-1:0]         rd_bank;
  logic [BW-1:0]         hd_bank;
  logic [BAW-1:0]        rd_baddr;
  logic [BAW-1:0]        hd_baddr;
  logic                  rd_act;
  logic                  retire;
  logic                  push;
  arb_state_e            state;
  logic                  done_q;
  logic                  perr_q;
`ifndef FRAM_ARB_FWD_EN
  logic                  raw_q;
`endif

  logic          rv_q [RL];
  logic [BW-1:0] rb_q [RL];
`ifdef FRAM_ARB_FWD_EN
  logic                  rf_q  [RL];
  logic [DATA_WIDTH-1:0] rfd_q [RL];
`endif

  // widen the narrow ports into queue-entry form
  always_comb begin
    rd_ax = '0;
    rd_ax[ADDR_WIDTH-1:0] = rp_addr;
    push_e = '0;
    push_e.addr[ADDR_WIDTH-1:0] = wp_addr;
    push_e.data[DATA_WIDTH-1:0] = wp_wdata;
  end

  assign rd_bank  = BW'(bank_of(rd_ax, BW));
  assign rd_baddr = BAW'(bankaddr_of(rd_ax, BW));
  assign hd_bank  = BW'(bank_of(head.addr, BW));
  assign hd_baddr = BAW'(bankaddr_of(head.addr, BW));

  assign rd_act   = rp_en & ~rst;
  assign retire   = ~rst & (count != '0) &
                    (~rp_en | (hd_bank != rd_bank));
  assign wp_ready = ~rst & (count < QFULL) & (state == RUN);
  assign push     = wp_valid & wp_ready;

  fram_wq_fifo #(
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_e),
    .pop        (retire),
    .look_addr  (rd_ax),
    .head       (head),
    .count      (count),
    .hit        (wq_hit),
    .hit_data   (wq_hit_data)
  );

  // read owns its bank; the head retires into any other bank
  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) begin
      bram_we[b]    = retire & (hd_bank == BW'(b));
      bram_en[b]    = bram_we[b] |
                      (rd_act & (rd_bank == BW'(b)));
      bram_addr[b]  = bram_we[b] ? hd_baddr : rd_baddr;
      bram_wdata[b] = head.data[DATA_WIDTH-1:0];
    end
  end

  // read-valid shift chain, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RL; i++) rv_q[i] <= 1'b0;
    end else begin
      rv_q[0] <= rp_en;
      for (int i = 1; i < RL; i++) rv_q[i] <= rv_q[i-1];
    end
  end

  // bank select and forwarded word follow the BRAM latency
  always_ff @(posedge clk) begin
    rb_q[0] <= rd_bank;
    for (int i = 1; i < RL; i++) rb_q[i] <= rb_q[i-1];
`ifdef FRAM_ARB_FWD_EN
    rf_q[0]  <= wq_hit;
    rfd_q[0] <= wq_hit_data[DATA_WIDTH-1:0];
    for (int i = 1; i < RL; i++) begin
      rf_q[i]  <= rf_q[i-1];
      rfd_q[i] <= rfd_q[i-1];
    end
`endif
  end

  // return mux: BRAM word, or the forwarded queue word
  always_comb begin
    rp_rdata = '0;
    if (rv_q[RL-1] & ~rst) begin
      rp_rdata = bram_rdata[rb_q[RL-1]];
`ifdef FRAM_ARB_FWD_EN
      if (rf_q[RL-1]) rp_rdata = rfd_q[RL-1];
`endif
    end
  end

  assign rp_rvalid = rv_q[RL-1] & ~rst;

  // flush handshake FSM with sticky protocol flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      done_q <= 1'b0;
      perr_q <= 1'b0;
`ifndef FRAM_ARB_FWD_EN
      raw_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        RUN: begin
          if (flush_req) state <= FLUSH;
        end
        FLUSH: begin
          if (wp_valid) perr_q <= 1'b1;
          if (count == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
`ifndef FRAM_ARB_FWD_EN
      if (rd_act & wq_hit) raw_q <= 1'b1;
`endif
    end
  end

  assign flush_done = done_q & ~rst;
  assign proto_err  = perr_q & ~rst;
  assign wq_empty   = (count == '0) | rst;
`ifndef FRAM_ARB_FWD_EN
  assign raw_hazard = raw_q & ~rst;
`endif

endmodule

// File: tb/tb_fram_bank_arbiter.sv
// tb_fram_bank_arbiter: directed + random stimulus against
// a queue-based reference model of the arbiter.
module tb_fram_bank_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int BN  = 4;
  localparam int BAW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          rp_en;
  logic [AW-1:0] rp_addr;
  logic [DW-1:0] rp_rdata;
  logic          rp_rvalid;
  logic          wp_valid;
  logic [AW-1:0] wp_addr;
  logic [DW-1:0] wp_wdata;
  logic          wp_ready;
  logic          flush_req;
  logic          flush_done;
  logic          wq_empty;
  logic          proto_err;
  logic          raw_hazard;
  logic [BAW-1:0] bram_addr  [BN];
  logic [DW-1:0]  bram_wdata [BN];
  logic [BN-1:0]  bram_we;
  logic [BN-1:0]  bram_en;
  logic [DW-1:0]  bram_rdata [BN];

  always #5 clk = ~clk;

  fram_bank_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BANK_NUM   (BN),
    .WQ_DEPTH   (4),
    .RD_LATENCY (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rp_en      (rp_en),
    .rp_addr    (rp_addr),
    .rp_rdata   (rp_rdata),
    .rp_rvalid  (rp_rvalid),
    .wp_valid   (wp_valid),
    .wp_addr    (wp_addr),
    .wp_wdata   (wp_wdata),
    .wp_ready   (wp_ready),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .wq_empty   (wq_empty),
    .proto_err  (proto_err),
`ifndef FRAM_ARB_FWD_EN
    .raw_hazard (raw_hazard),
`endif
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_we    (bram_we),
    .bram_en    (bram_en),
    .bram_rdata (bram_rdata)
  );

`ifdef FRAM_ARB_FWD_EN
  assign raw_hazard = 1'b0;
`endif

  // behavioural BRAM banks, one-cycle read latency
  logic [DW-1:0] bmem [BN][1<<BAW];
  logic          pl_we;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;

  always @(posedge clk) begin
    if (pl_we) bmem[pl_a[1:0]][pl_a[AW-1:2]] <= pl_d;
    for (int b = 0; b < BN; b++) begin
      if (bram_en[b]) begin
        if (bram_we[b]) bmem[b][bram_addr[b]] <= bram_wdata[b];
        else bram_rdata[b] <= bmem[b][bram_addr[b]];
      end
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  logic [DW-1:0] ref_mem [32];
  int            mode;
  bit            m_perr;
  bit            m_raw;
  bit            pv;
  logic [DW-1:0] pd;
  int            n_chk;
  int            n_fail;

  logic [BN-1:0]  o_en;
  logic [BN-1:0]  o_we;
  logic [BAW-1:0] o_baddr [BN];
  logic           o_ready;
  logic           o_rvalid;
  logic [DW-1:0]  o_rdata;
  logic           o_done;
  logic           o_perr;
  logic           o_raw;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_cycle();
    logic [1:0]    rb;
    logic [1:0]    hb;
    bit            ret;
    bit            erdy;
    bit            hit;
    logic [BN-1:0] een;
    logic [BN-1:0] ewe;
    logic [DW-1:0] hd;
    o_en = bram_en;
    o_we = bram_we;
    for (int b = 0; b < BN; b++) o_baddr[b] = bram_addr[b];
    o_ready  = wp_ready;
    o_rvalid = rp_rvalid;
    o_rdata  = rp_rdata;
    o_done   = flush_done;
    o_perr   = proto_err;
    o_raw    = raw_hazard;
    if (rst) begin
      check("rst_en", bram_en, 0);
      check("rst_we", bram_we, 0);
      check("rst_ready", wp_ready, 0);
      check("rst_empty", wq_empty, 1);
      check("rst_rvalid", rp_rvalid, 0);
      check("rst_rdata", rp_rdata, 0);
      check("rst_done", flush_done, 0);
      check("rst_perr", proto_err, 0);
      check("rst_raw", raw_hazard, 0);
      q.delete();
      mode = 0; m_perr = 0; m_raw = 0; pv = 0;
      return;
    end
    rb  = rp_addr[1:0];
    ret = (q.size() > 0) && (!rp_en || q[0].a[1:0] != rb);
    hb  = 2'd0;
    if (ret) hb = q[0].a[1:0];
    een = '0;
    ewe = '0;
    if (rp_en) een[rb] = 1'b1;
    if (ret) begin
      een[hb] = 1'b1;
      ewe[hb] = 1'b1;
    end
    erdy = (q.size() < 4) && (mode == 0);
    check("bram_en", bram_en, een);
    check("bram_we", bram_we, ewe);
    if (rp_en) check("rd_baddr", bram_addr[rb], rp_addr[AW-1:2]);
    if (ret) begin
      check("wr_baddr", bram_addr[hb], q[0].a[AW-1:2]);
      check("wr_data", bram_wdata[hb], q[0].d);
    end
    check("wp_ready", wp_ready, erdy);
    check("wq_empty", wq_empty, q.size() == 0);
    check("rp_rvalid", rp_rvalid, pv);
    check("rp_rdata", rp_rdata, pv ? pd : '0);
    check("flush_done", flush_done, mode == 2);
    check("proto_err", proto_err, m_perr);
    check("raw_hazard", raw_hazard, m_raw);
    if (mode == 1 && wp_valid) m_perr = 1;
    pv = rp_en;
    if (rp_en) begin
      hit = 0;
      hd  = ref_mem[rp_addr[4:0]];
      foreach (q[i]) begin
        if (q[i].a == rp_addr) begin
          hit = 1;
          hd  = q[i].d;
        end
      end
`ifdef FRAM_ARB_FWD_EN
      pd = hd;
`else
      pd = ref_mem[rp_addr[4:0]];
      if (hit) m_raw = 1;
`endif
    end
    case (mode)
      0:       if (flush_req) mode = 1;
      1:       if (q.size() == 0) mode = 2;
      default: mode = 0;
    endcase
    if (ret) begin
      ref_mem[q[0].a[4:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (wp_valid && erdy) q.push_back('{wp_addr, wp_wdata});
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rp_en = 0; rp_addr = '0;
    wp_valid = 0; wp_addr = '0; wp_wdata = '0;
    flush_req = 0;
  endtask

  logic [AW-1:0] wa [5];
  int nacc;
  int acc5;
  int nwe;
  int ndone;
  int done_k;

  initial begin
    n_chk = 0; n_fail = 0;
    mode = 0; m_perr = 0; m_raw = 0; pv = 0; pd = '0;
    rst = 1; pl_we = 0; pl_a = '0; pl_d = '0;
    idle();
    for (int i = 0; i < 32; i++) begin
      pl_we = 1;
      pl_a  = AW'(i);
      pl_d  = (i == 5) ? 32'hA5A5_A5A5 : $urandom;
      ref_mem[i] = pl_d;
      step();
    end
    pl_we = 0;
    rst = 0;
    step();
    check("ready_after_rst", o_ready, 1);

    rp_en = 1; rp_addr = 14'h005;
    step();
    check("rd5_en", o_en, 4'b0010);
    check("rd5_baddr", o_baddr[1], 12'h001);
    rp_en = 0;
    step();
    check("rd5_valid", o_rvalid, 1);
    check("rd5_data", o_rdata, 32'hA5A5_A5A5);

    wp_valid = 1; wp_addr = 14'h009; wp_wdata = 32'h0BAD_F00D;
    rp_en = 1; rp_addr = 14'h001;
    step();
    check("cf_we_a", o_we[1], 0);
    wp_valid = 0; rp_addr = 14'h005;
    step();
    check("cf_we_b", o_we[1], 0);
    rp_addr = 14'h00D;
    step();
    check("cf_we_c", o_we[1], 0);
    rp_addr = 14'h002;
    step();
    check("cf_we_d", o_we[1], 1);
    idle();
    step();

    wa[0] = 14'h010; wa[1] = 14'h014; wa[2] = 14'h018;
    wa[3] = 14'h01C; wa[4] = 14'h010;
    nacc = 0; acc5 = -1;
    for (int c = 0; c < 20 && nacc < 5; c++) begin
      rp_en    = (c < 8);
      rp_addr  = AW'((c % 4) * 4);
      wp_valid = 1;
      wp_addr  = wa[nacc];
      wp_wdata = $urandom;
      step();
      if (c == 4) check("bp_ready_low", o_ready, 0);
      if (o_ready) begin
        if (nacc == 4) acc5 = c;
        nacc++;
      end
    end
    check("bp_acc5_cycle", acc5, 9);
    idle();
    repeat (6) step();

    wp_valid = 1; wp_addr = 14'h010; wp_wdata = 32'hDEAD_BEEF;
    rp_en = 1; rp_addr = 14'h000;
    step();
    wp_wdata = 32'h1234_5678; rp_addr = 14'h004;
    step();
    wp_valid = 0; rp_addr = 14'h010;
    step();
    check("raw_before", o_raw, 0);
    rp_en = 0;
    step();
`ifdef FRAM_ARB_FWD_EN
    check("fwd_data", o_rdata, 32'h1234_5678);
`else
    check("raw_set", o_raw, 1);
`endif
    idle();
    repeat (4) step();

    rp_en = 1; rp_addr = 14'h00E; wp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wp_addr  = AW'(2 + 4 * i);
      wp_wdata = $urandom;
      step();
    end
    wp_valid = 0; rp_en = 0; flush_req = 1;
    step();
    flush_req = 0;
    nwe = int'(o_we[2]); ndone = 0; done_k = -1;
    for (int k = 1; k <= 8; k++) begin
      wp_valid = (k == 1);
      step();
      if (k == 1) check("fl_ready_low", o_ready, 0);
      nwe += int'(o_we[2]);
      if (o_done) begin
        ndone++;
        done_k = k;
      end
    end
    check("fl_retires", nwe, 3);
    check("fl_done_cnt", ndone, 1);
    check("fl_done_cyc", done_k, 4);
    check("fl_perr", o_perr, 1);
    idle();

    rp_en = 1; rp_addr = 14'h003;
    wp_valid = 1; wp_addr = 14'h007; wp_wdata = $urandom;
    step();
    step();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_en", o_en, 0);
      check("mr_ready", o_ready, 0);
      check("mr_rvalid", o_rvalid, 0);
    end
    rst = 0;
    idle();
    step();
    check("mr_ready_rel", o_ready, 1);
    check("mr_perr_clr", o_perr, 0);
    check("mr_q_drop", o_we, 0);

    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      rp_en     = $urandom_range(0, 1) != 0;
      rp_addr   = AW'($urandom_range(0, 31));
      wp_valid  = $urandom_range(0, 2) != 0;
      wp_addr   = AW'($urandom_range(0, 31));
      wp_wdata  = $urandom;
      flush_req = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 0;
    idle();
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
